// File: rtl/cache_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM cache port arbiter: FSM states, port owner,
// and a width helper for the saturating counters.
package cache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MISS    = 2'd1,
        ST_REISSUE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_IF  = 1'b1
    } arb_owner_t;

    localparam int PERF_W   = 16;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    // Bits needed to hold 0..max_val; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cache_port_arbiter_sat_counter.sv
// arb_sat_counter: up-counter that sticks at MAX; clr and rst both zero it,
// clr taking priority over inc.
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cacheBlock between the IF and MEM ports: grants in IDLE, rides out
// misses on a latched request, and reissues it once. CACHE_ARB_PERF_EN adds hit/miss counters.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int IF_STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_din,
    output logic              cache_write,
    input  logic [DATA_W-1:0] cache_dout,
    input  logic              cache_stall
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_hits,
    output logic [PERF_W-1:0] perf_misses
`endif
);

    localparam int SC_W = cnt_width(IF_STARVE_LIMIT);

    typedef struct packed {
        arb_owner_t        owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    arb_state_t      state, state_nxt;
    req_t            lat, winner, drive;
    logic [SC_W-1:0] starve_cnt;
    logic            grant, if_win, done;

    always_comb begin
        grant  = if_req | mem_req;
        if_win = if_req & (~mem_req | (starve_cnt == SC_W'(IF_STARVE_LIMIT)));
        winner = '0;
        if (if_win) begin
            winner.owner = OWN_IF;
            winner.addr  = if_addr;
        end else if (mem_req) begin
            winner.owner = OWN_MEM;
            winner.we    = mem_we;
            winner.addr  = mem_addr;
            winner.wdata = mem_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        drive     = '0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    drive = winner;
                    if (cache_stall) state_nxt = ST_MISS;
                    else             done      = 1'b1;
                end
            end
            ST_MISS: begin
                drive = lat;
                if (!cache_stall) state_nxt = ST_REISSUE;
            end
            ST_REISSUE: begin
                drive = lat;
                if (cache_stall) begin
                    state_nxt = ST_MISS;
                end else begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Keep the cache and both ports quiet while reset is applied.
        if (rst) begin
            drive = '0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && grant && cache_stall) lat <= winner;
        end
    end

    always_comb begin
        cache_addr  = drive.addr;
        cache_din   = drive.wdata;
        cache_write = drive.we;
        if_valid    = done & (drive.owner == OWN_IF);
        mem_valid   = done & (drive.owner == OWN_MEM);
        if_rdata    = if_valid  ? cache_dout : '0;
        mem_rdata   = mem_valid ? cache_dout : '0;
        stall_if    = if_req  & ~if_valid;
        stall_mem   = mem_req & ~mem_valid;
    end

    // Counts MEM completions that left a fetch waiting; any idle-IF cycle or IF completion resets it.
    arb_sat_counter #(
        .WIDTH (SC_W),
        .MAX   (IF_STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_valid & if_req),
        .clr   (if_valid | ~if_req),
        .count (starve_cnt)
    );

`ifdef CACHE_ARB_PERF_EN
    logic idle_grant;
    assign idle_grant = (state == ST_IDLE) & grant & ~rst;

    arb_sat_counter #(
        .WIDTH (PERF_W),
        .MAX   (PERF_MAX)
    ) u_perf_hits (
        .clk   (clk),
        .rst   (rst),
        .inc   (idle_grant & ~cache_stall),
        .clr   (1'b0),
        .count (perf_hits)
    );

    arb_sat_counter #(
        .WIDTH (PERF_W),
        .MAX   (PERF_MAX)
    ) u_perf_misses (
        .clk   (clk),
        .rst   (rst),
        .inc   (idle_grant & cache_stall),
        .clr   (1'b0),
        .count (perf_misses)
    );
`endif

endmodule
